// File: rtl/mem_pkg.sv
// Shared types and constants for the sync_mem_pipe data memory.
package mem_pkg;

    // Controller state: clear sweep after reset, then normal operation.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int RD_LAT_MAX = 4;
    localparam int BYTE_W     = 8;

    // Number of byte lanes in a data word.
    function automatic int be_width(input int dw);
        return dw / BYTE_W;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read response pipeline: RD_LAT stages of valid/data/err with synchronous flush.
// Data in a stage only advances with a valid token, so the last stage holds
// the most recent response while the output is idle.
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DW     = 16,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_err,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_err
);

    // Out-of-range latencies are clamped to the supported 1..RD_LAT_MAX.
    localparam int LAT = (RD_LAT < 1) ? 1 : ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);

    logic [LAT-1:0] vld;
    logic [LAT-1:0] err;
    logic [DW-1:0]  dat [LAT];

    // Shift tokens one stage per cycle; flush drops everything in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage
        // samples the previous stage's pre-edge value.
        if (flush) begin
            vld <= '0;
            err <= '0;
            for (int i = 0; i < LAT; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            err[0] <= in_valid & in_err;
            if (in_valid) begin
                dat[0] <= in_data;
            end
            for (int i = 1; i < LAT; i++) begin
                vld[i] <= vld[i-1];
                err[i] <= err[i-1];
                if (vld[i-1]) begin
                    dat[i] <= dat[i-1];
                end
            end
        end
    end

    assign out_valid = vld[LAT-1];
    assign out_err   = err[LAT-1];
    assign out_data  = dat[LAT-1];

endmodule

// File: rtl/sync_mem_pipe.sv
// Single-port data memory with valid/ready requests, byte-lane writes,
// a configurable read pipeline and a hardware clear sweep after reset.
// Optional feature: define MEM_STATS_EN to add saturating rd_count/wr_count.
module sync_mem_pipe
    import mem_pkg::*;
#(
    parameter int            DW        = 16,
    parameter int            AW        = 16,
    parameter int            DEPTH     = 256,
    parameter int            RD_LAT    = 1,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [AW-1:0]           req_addr,
    input  logic [DW-1:0]           req_wdata,
    input  logic [be_width(DW)-1:0] req_be,
    output logic                    resp_valid,
    output logic [DW-1:0]           resp_rdata,
    output logic                    resp_err,
    output logic                    wr_err,
    output logic                    init_done
`ifdef MEM_STATS_EN
    ,
    output logic [15:0]             rd_count,
    output logic [15:0]             wr_count
`endif
);

    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BE_W = be_width(DW);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] init_cnt;
    logic [DW-1:0] mem [DEPTH];

    logic          accept;
    logic          acc_wr;
    logic          acc_rd;
    logic          addr_ok;
    logic [IW-1:0] addr_idx;
    logic [DW-1:0] rd_data;

    // Full-width range check: high address bits never alias into the array.
    assign addr_ok  = ({1'b0, req_addr} < (AW+1)'(DEPTH));
    assign addr_idx = req_addr[IW-1:0];
    assign accept   = req_valid & req_ready;
    assign acc_wr   = accept & req_wen;
    assign acc_rd   = accept & ~req_wen;
    assign rd_data  = addr_ok ? mem[addr_idx] : '0;

    // Next-state and status outputs derived from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_cnt == IW'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // State register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
        end
    end

    // Memory array: clear sweep during INIT, byte-lane writes during RUN.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; it is cleared by the INIT sweep
        // so it can map onto plain RAM.
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[init_cnt] <= CLEAR_VAL;
            end else if (acc_wr && addr_ok) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (req_be[b]) begin
                        mem[addr_idx][b*BYTE_W +: BYTE_W] <= req_wdata[b*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    // Out-of-range write flag, one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_err <= 1'b0;
        end else begin
            wr_err <= acc_wr & ~addr_ok;
        end
    end

    mem_rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .flush     (rst),
        .in_valid  (acc_rd),
        .in_data   (rd_data),
        .in_err    (~addr_ok),
        .out_valid (resp_valid),
        .out_data  (resp_rdata),
        .out_err   (resp_err)
    );

`ifdef MEM_STATS_EN
    // Saturating counters of accepted reads and writes (RUN only by construction).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (acc_rd && rd_count != 16'hFFFF) begin
                rd_count <= rd_count + 16'd1;
            end
            if (acc_wr && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/sync_mem_pipe.md
Name: sync_mem_pipe

Overview:
Parametrised single-port data memory with a valid/ready request interface, byte-lane write enables and a configurable read pipeline. It replaces the fixed 16x16-bit memory in the processor datapath. After every reset it sweeps and clears its contents with a hardware init state machine. Out-of-range accesses are flagged instead of aliasing.

Parameters:
DW, 16, data width in bits; multiple of 8.
AW, 16, request address width in bits; word addressed.
DEPTH, 256, number of words; 1 <= DEPTH <= 2^AW.
RD_LAT, 1, read latency in cycles; legal range 1..4.
CLEAR_VAL, 0, word value written to every location during init.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_wen  in  1  1 = write, 0 = read.
req_addr  in  AW  word address.
req_wdata  in  DW  write data.
req_be  in  DW/8  byte-lane write enables; ignored for reads.
resp_valid  out  1  read data valid; one-cycle pulse per read.
resp_rdata  out  DW  read data.
resp_err  out  1  qualifies resp_valid; read address was >= DEPTH.
wr_err  out  1  one-cycle pulse; accepted write address was >= DEPTH.
init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Reset: while rst=1 on an edge, the FSM goes to INIT with init counter 0. The read pipeline is flushed. req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, wr_err=0, init_done=0.
- FSM states:
  - INIT: each cycle writes CLEAR_VAL to mem[cnt] and increments cnt. When cnt==DEPTH-1 is written, go to RUN on the next edge. INIT lasts exactly DEPTH cycles after reset is released.
  - RUN: init_done=1 and req_ready=1 (combinational from state). RUN has no exit except reset.
- Acceptance: a request is accepted on an edge where req_valid & req_ready. The block accepts at most one request per cycle, with full throughput.
- Writes:
  - Byte lane i of mem[addr] is updated on the acceptance edge when req_be[i]=1; other lanes are untouched.
  - No response is generated.
  - If addr >= DEPTH, memory is unchanged and wr_err pulses high in the cycle after acceptance.
- Reads:
  - Data is sampled from memory at the acceptance edge. resp_valid and resp_rdata appear exactly RD_LAT cycles after the acceptance edge.
  - The response cannot be back-pressured.
  - If addr >= DEPTH: resp_rdata=0 and resp_err=1 with that response.
  - resp_rdata holds its last value when resp_valid=0. resp_err is 0 when resp_valid=0.
- Ordering:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Back-to-back reads return in request order, one per cycle.
- Reset mid-operation: in-flight reads are dropped (no resp_valid), INIT restarts at 0, and all contents are re-cleared.
- Address compare uses the full AW bits; no aliasing of high bits.

Optional Feature:
MEM_STATS_EN defined:
- Adds outputs rd_count[15:0] and wr_count[15:0].
- They count accepted reads and accepted writes, including out-of-range accesses.
- Both saturate at 16'hFFFF and clear to 0 on reset.
- They do not count during INIT.

MEM_STATS_EN undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package mem_pkg holds:
  - FSM state typedef (INIT, RUN);
  - constants RD_LAT_MAX=4 and BYTE_W=8;
  - a function computing DW/8.
- One sub-module, mem_rd_pipe: a parametrised RD_LAT-stage valid/data/err shift register with synchronous flush. The array and FSM stay in sync_mem_pipe.

Test Plan:
1. Defaults, rst high 2 cycles then low: req_ready=0 for exactly 256 cycles, then init_done=1 and req_ready=1; a read of addr 16'h0005 returns 16'h0000 one cycle later.
2. Write 16'hABCD to addr 16'h0001 with be=2'b11, then write 16'h1234 with be=2'b01 → read of addr 1 returns 16'hAB34; reads of addrs 1, 2, 3 on consecutive cycles give three consecutive resp_valid pulses in order.
3. RD_LAT=3: read accepted at cycle t → resp_valid exactly at t+3; four back-to-back reads → four consecutive pulses.
4. Out-of-range, DEPTH=256: write to addr 16'h0100 → wr_err pulse, mem[0] unchanged; read of 16'hFFFF → resp_valid=1, resp_err=1, resp_rdata=0.
5. Read issued, rst asserted next cycle with RD_LAT=2 → no resp_valid ever appears for it; after re-init, the earlier-written addr 1 reads 16'h0000.
6. With MEM_STATS_EN: 3 reads and 2 writes accepted → rd_count=3, wr_count=2; after 70000 reads, rd_count=16'hFFFF.
